// File: rtl/parity_pkg.sv
// Shared parity constants and helpers, used by the parity checker and generator.
package parity_pkg;

  localparam int DEFAULT_INPUT_WIDTH = 3;
  localparam int DEFAULT_CNT_WIDTH   = 16;
  localparam int MAX_PARITY_WIDTH    = 64;

  // Returns 1 when v holds an odd number of ones. Narrower vectors are
  // zero-extended by the caller, which leaves the result unchanged.
  function automatic logic odd_ones(input logic [MAX_PARITY_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/parity_pipe_reg.sv
// One-entry valid/ready pipeline register; full throughput, holds stable under backpressure.
module parity_pipe_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/even_parity_checker.sv
// Even-parity checker with sticky error flag; the saturating error counter is
// built only when PARITY_ERR_CNT_EN is defined, otherwise err_count is tied to 0.
module even_parity_checker
  import parity_pkg::*;
#(
  parameter int input_width = DEFAULT_INPUT_WIDTH,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [input_width:0]   in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [input_width-1:0] out,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_sticky,
  input  logic                   err_clr,
  output logic [CNT_WIDTH-1:0]   err_count
);

  if (input_width < 1 || input_width + 1 > MAX_PARITY_WIDTH) begin : g_bad_width
    $error("even_parity_checker: input_width out of range");
  end

  logic                 accept;
  logic                 parity_bad;
  logic                 err_event;
  logic [input_width:0] pipe_out;

  assign accept     = in_valid && in_ready;
  assign parity_bad = odd_ones(MAX_PARITY_WIDTH'(in));
  assign err_event  = accept && parity_bad;

  parity_pipe_reg #(
    .WIDTH(input_width + 1)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({in[input_width:1], parity_bad}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (pipe_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out     = pipe_out[input_width:1];
  assign out_err = pipe_out[0];

  // A new error wins over a coincident clear so the event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_sticky <= 1'b0;
    else if (err_event) err_sticky <= 1'b1;
    else if (err_clr)   err_sticky <= 1'b0;
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_event) begin
      if (err_clr)               err_cnt_q <= CNT_WIDTH'(1);
      else if (err_cnt_q != '1)  err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_even_parity_checker.sv
// Bench for even_parity_checker: queue-based reference model with per-cycle compare, plus directed literal checks.
module tb_even_parity_checker;

  localparam int IW   = 3;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW:0]   in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] out;
  logic          out_err;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          err_sticky;
  logic          err_clr = 1'b0;
  logic [CW-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  even_parity_checker #(.input_width(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .err_sticky(err_sticky), .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of words waiting downstream plus error bookkeeping.
  typedef struct packed { logic [IW-1:0] d; logic e; } word_t;
  word_t m_q[$];
  bit    m_sticky = 1'b0;
  int    m_count  = 0;
  bit    m_ready, m_acc, m_bad;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_sticky = 1'b0;
      m_count  = 0;
    end else begin
      m_ready = (m_q.size() == 0) || out_ready;
      m_acc   = in_valid && m_ready;
      m_bad   = ($countones(in) % 2) == 1;
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (m_acc) m_q.push_back('{d: in[IW:1], e: m_bad});
      if (m_acc && m_bad) begin
        m_sticky = 1'b1;
        m_count  = err_clr ? 1 : ((m_count < MAXC) ? m_count + 1 : MAXC);
      end else if (err_clr) begin
        m_sticky = 1'b0;
        m_count  = 0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    chk("m_out_valid", int'(out_valid), int'(m_q.size() != 0));
    chk("m_in_ready", int'(in_ready), int'((m_q.size() == 0) || out_ready));
    if (m_q.size() != 0) begin
      chk("m_out", int'(out), int'(m_q[0].d));
      chk("m_out_err", int'(out_err), int'(m_q[0].e));
    end
    chk("m_err_sticky", int'(err_sticky), int'(m_sticky));
    chk("m_err_count", int'(err_count), CNT_EN ? m_count : 0);
  end

  logic [IW:0] stream [8] = '{4'b0000, 4'b0011, 4'b0101, 4'b1001,
                              4'b1111, 4'b0110, 4'b1110, 4'b0001};
  logic [IW:0] errw   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0111};

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out", int'(out), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_count", int'(err_count), 0);

    @(negedge clk); rst = 1'b0;

    // Clean word
    @(negedge clk); in = 4'b1010; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #2;
    chk("good_valid", int'(out_valid), 1);
    chk("good_out", int'(out), 3'b101);
    chk("good_err", int'(out_err), 0);
    chk("good_count", int'(err_count), 0);

    // Errored word
    @(negedge clk); in = 4'b1011; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #2;
    chk("bad_out", int'(out), 3'b101);
    chk("bad_err", int'(out_err), 1);
    chk("bad_sticky", int'(err_sticky), 1);
    chk("bad_count", int'(err_count), CNT_EN ? 1 : 0);

    // Backpressure: a second word waits while the first is held
    @(negedge clk); out_ready = 1'b0; in = 4'b0110; in_valid = 1'b1;
    @(negedge clk); in = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out", int'(out), 3'b011);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2 chk("unstall_in_ready", int'(in_ready), 1);
    @(negedge clk); in_valid = 1'b0;
    #2;
    chk("reload_valid", int'(out_valid), 1);
    chk("reload_out", int'(out), 3'b110);
    @(negedge clk);
    #2 chk("drain_valid", int'(out_valid), 0);

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); in = stream[i]; in_valid = 1'b1;
      #2 chk("stream_in_ready", int'(in_ready), 1);
    end
    @(negedge clk); in_valid = 1'b0;
    #2;
    chk("stream_last_out", int'(out), 3'b000);
    chk("stream_last_err", int'(out_err), 1);

    // Clear, then saturate
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #2;
    chk("clr_sticky", int'(err_sticky), 0);
    chk("clr_count", int'(err_count), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in = errw[i]; in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    #2;
    chk("sat_count", int'(err_count), CNT_EN ? 3 : 0);
    chk("sat_sticky", int'(err_sticky), 1);
    @(negedge clk); in = 4'b1110; in_valid = 1'b1; err_clr = 1'b1;
    @(negedge clk); in_valid = 1'b0; err_clr = 1'b0;
    #2;
    chk("clr_err_count", int'(err_count), CNT_EN ? 1 : 0);
    chk("clr_err_sticky", int'(err_sticky), 1);

    // Asynchronous reset while a word is held
    @(negedge clk); out_ready = 1'b0; in = 4'b0101; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #2 chk("held_valid", int'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_count", int'(err_count), 0);
    chk("arst_sticky", int'(err_sticky), 0);
    chk("arst_out", int'(out), 0);

    // First edge after reset release accepts a word
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; in = 4'b1010; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #2;
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_out", int'(out), 3'b101);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/even_parity_checker.md
EVEN_PARITY_CHECKER -- requirements
Module: even_parity_checker

Interface
REQ-001 The block SHALL take parameter `input_width`, default 3: the number of data bits per word, excluding the parity bit.
REQ-002 The block SHALL take parameter `CNT_WIDTH`, default 16: the width of the error counter.
REQ-003 Port `clk` SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-004 Port `rst` SHALL be an input, 1 bit wide: reset, asynchronous and active-high.
REQ-005 Port `in` SHALL be an input, `input_width`+1 bits wide: a received word with data in the upper bits and even parity in the LSB.
REQ-006 Port `in_valid` SHALL be an input, 1 bit wide: `in` holds a word.
REQ-007 Port `in_ready` SHALL be an output, 1 bit wide: the block can accept a word.
REQ-008 Port `out` SHALL be an output, `input_width` bits wide: the data bits with the parity bit stripped.
REQ-009 Port `out_err` SHALL be an output, 1 bit wide: the parity check failed for the word on `out`.
REQ-010 Port `out_valid` SHALL be an output, 1 bit wide: `out` and `out_err` are valid.
REQ-011 Port `out_ready` SHALL be an input, 1 bit wide: the downstream block accepts the word.
REQ-012 Port `err_sticky` SHALL be an output, 1 bit wide: at least one error has occurred since reset or since the last clear.
REQ-013 Port `err_clr` SHALL be an input, 1 bit wide: a one-cycle pulse that clears `err_sticky` and `err_count`.
REQ-014 Port `err_count` SHALL be an output, `CNT_WIDTH` bits wide: the saturating count of errored words.

Function
REQ-015 A word SHALL be accepted on a cycle where `in_valid` and `in_ready` are both high.
REQ-016 A word SHALL be delivered on a cycle where `out_valid` and `out_ready` are both high.
REQ-017 `in_ready` SHALL equal (!`out_valid` || `out_ready`): a one-entry pipeline register that supports full throughput.
REQ-018 Latency SHALL be exactly one cycle from acceptance to `out_valid` high.
REQ-019 On acceptance, `out` SHALL be loaded with `in`[`input_width`:1].
REQ-020 On acceptance, `out_err` SHALL be loaded with the XOR-reduction of all `input_width`+1 bits of `in`: 1 means an odd number of ones, which is an error.
REQ-021 While `out_valid` is high and `out_ready` is low, `out`, `out_err` and `out_valid` SHALL hold stable.
REQ-022 When a word is delivered and no new word is accepted in the same cycle, `out_valid` SHALL fall.
REQ-023 When a word is delivered and a new word is accepted in the same cycle, the output register SHALL be reloaded and `out_valid` SHALL stay high.
REQ-024 `err_sticky` SHALL set on acceptance of an errored word and hold until `err_clr` or reset.
REQ-025 `err_count` SHALL increment by 1 on acceptance of an errored word.
REQ-026 `err_count` SHALL saturate at all-ones and never wrap.
REQ-027 When `err_clr` coincides with acceptance of an errored word, the result SHALL be `err_count` = 1 and `err_sticky` = 1, so the new event is not lost.
REQ-028 When `err_clr` is high and no error is accepted that cycle, the result SHALL be `err_count` = 0 and `err_sticky` = 0 on the next cycle.
REQ-029 Errors SHALL be counted at acceptance, independent of downstream stalls.
REQ-030 A word with `input_width` = 0 (parity bit only) is not supported; `input_width` SHALL be at least 1.

Reset
REQ-031 While `rst` is high, `out_valid` SHALL be 0, `out` SHALL be 0, `out_err` SHALL be 0, `err_sticky` SHALL be 0 and `err_count` SHALL be 0, asynchronously.
REQ-032 `in_ready` SHALL be 1 one delta after `rst` asserts, since it follows from `out_valid` = 0.
REQ-033 A word held in the output register when `rst` asserts mid-operation SHALL be discarded, and no partial handshake SHALL complete.
REQ-034 The first acceptance after reset SHALL be possible on the first rising edge after `rst` deasserts.

Configuration
REQ-035 Macro `PARITY_ERR_CNT_EN` defined: `err_count` and its saturating counter SHALL be built as specified.
REQ-036 Macro `PARITY_ERR_CNT_EN` undefined: `err_count` SHALL be tied to 0, no counter flops SHALL exist, and `err_sticky` and the datapath SHALL be unchanged.

Structure
REQ-037 Shared package `parity_pkg` SHALL hold the default width constants and a function computing even parity of a vector, reused with `even_parity_generator`.
REQ-038 The valid/ready register SHALL be the sub-module `parity_pipe_reg`, parameterised by width and carrying {`out`, `out_err`}.
REQ-039 Top-level logic SHALL be limited to the parity check, sticky flag, counter and macro gating.

Verification
REQ-040 With `input_width` = 3 and `out_ready` = 1, sending `in` = 4'b1010 SHALL give `out` = 3'b101 and `out_err` = 0 one cycle later, with `err_count` unchanged.
REQ-041 Sending `in` = 4'b1011 SHALL give `out` = 3'b101 and `out_err` = 1, with `err_sticky` = 1 and `err_count` = 1.
REQ-042 With `out_ready` = 0 held for 5 cycles after one word, `in_ready` SHALL be 0 and `out` SHALL stay stable; after `out_ready` rises, the word SHALL be delivered once, with no loss or duplication.
REQ-043 A back-to-back stream of 8 words with `out_ready` = 1 SHALL be accepted every cycle and delivered in order one cycle later.
REQ-044 With `CNT_WIDTH` = 2, 5 errored words SHALL leave `err_count` = 3; an `err_clr` pulse coincident with a 6th errored word SHALL then give `err_count` = 1 and `err_sticky` = 1.
REQ-045 Asserting `rst` while `out_valid` = 1 SHALL immediately give `out_valid` = 0, `err_count` = 0 and `in_ready` = 1; the build with `PARITY_ERR_CNT_EN` undefined SHALL keep `err_count` = 0 throughout.
